// File: rtl/spram_stream_reader.sv
// spram_stream_reader: sweeps a word range of the single-port buffer
// and streams the words out in address order over valid/ready.
module spram_stream_reader #(
    parameter int W_DATA = 32,
    parameter int W_WORD = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [W_WORD-1:0] base_addr,
    input  logic [W_WORD:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [W_WORD-1:0] mem_addr,
    input  logic [W_DATA-1:0] mem_dout,
    output logic              m_valid,
    output logic [W_DATA-1:0] m_data,
    input  logic              m_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [W_WORD:0]   CNT_ONE  = 1;
    localparam logic [W_WORD-1:0] ADDR_ONE = 1;

    state_t              state_q;
    logic [W_WORD-1:0]   addr_q;
    logic [W_WORD:0]     remain_q;
    logic [W_WORD:0]     sent_q;
    logic [W_WORD:0]     len_q;
    logic                inflight_q;
    logic [1:0]          cnt_q;
    logic [1:0]          cnt_nxt;
    logic [W_DATA-1:0]   tail_q;
    logic                pop;
    logic                push;
    logic                issue;
    logic [2:0]          occ;

    // Credit check: a read may issue only if its word will have a slot.
    always_comb begin
        pop   = m_valid & m_ready;
        push  = inflight_q;
        occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == S_READ) && (remain_q != '0) && (occ < 3'd2);
        cnt_nxt = cnt_q;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt_q + 2'd1;
            2'b01:   cnt_nxt = cnt_q - 2'd1;
            default: cnt_nxt = cnt_q;
        endcase
    end

    assign mem_en   = issue;
    assign mem_addr = addr_q;
    assign mem_we   = 1'b0;

    // Transfer control: range latch, issue bookkeeping, busy/done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            sent_q   <= '0;
            len_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                sent_q <= sent_q + CNT_ONE;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= length;
                        len_q    <= length;
                        sent_q   <= '0;
                        busy     <= 1'b1;
                        if (length == '0) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        addr_q   <= addr_q + ADDR_ONE;
                        remain_q <= remain_q - CNT_ONE;
                        if (remain_q == CNT_ONE) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && (sent_q == len_q - CNT_ONE)) begin
                        state_q <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry skid FIFO; m_data is the head register itself.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= issue;
            cnt_q      <= cnt_nxt;
            m_valid    <= (cnt_nxt != 2'd0);
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        m_data <= mem_dout;
                    end else begin
                        tail_q <= mem_dout;
                    end
                end
                2'b01: begin
                    if (cnt_q == 2'd2) begin
                        m_data <= tail_q;
                    end
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        m_data <= mem_dout;
                    end else begin
                        m_data <= tail_q;
                        tail_q <= mem_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_stream_reader.sv
// tb_spram_stream_reader: vector table, corner sequences and random
// transfers checked against an address-order model of the buffer.
module tb_spram_stream_reader;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  length = '0;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_dout = '0;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] spm [DEPTH];

    typedef struct {
        int base;
        int len;
        int mode;
        int inject;
        int exp_done;
    } vec_t;

    vec_t vecs [6];

    spram_stream_reader #(
        .W_DATA (32),
        .W_WORD (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    // Buffer model: one-cycle registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= spm[mem_addr];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input int base, input int len, input int mode,
                            input int inject, input int exp_done);
        logic [31:0] got [$];
        int          addrs [$];
        int          first_en = -1;
        int          first_v = -1;
        int          done_at = -1;
        int          burst = 0;
        int          r;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [31:0] pd = '0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 4'(base);
        length    = 5'(len);
        m_ready   = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (inject != 0 && i == 6) begin
                start     = 1'b1;
                base_addr = 4'd5;
                length    = 5'd3;
            end
            if (mode != 0) begin
                if (burst > 0) begin
                    burst--;
                    m_ready = 1'b0;
                end else begin
                    r = $urandom_range(0, 9);
                    if (r == 0) begin
                        burst   = $urandom_range(5, 8);
                        m_ready = 1'b0;
                    end else begin
                        m_ready = (r >= 4);
                    end
                end
            end
            @(negedge clk);
            if (i == 1) begin
                chk("busy_after_start", longint'(busy), 1);
            end
            chk("occupancy_le_2",
                longint'((addrs.size() - got.size()) <= 2), 1);
            chk("mem_we_zero", longint'(mem_we), 0);
            if (pv && !pr) begin
                chk("stall_valid_hold", longint'(m_valid), 1);
                chk("stall_data_hold", longint'(m_data), longint'(pd));
            end
            if (mem_en) begin
                addrs.push_back(int'(mem_addr));
                if (first_en < 0) first_en = i;
            end
            if (m_valid && first_v < 0) first_v = i;
            if (m_valid && m_ready) got.push_back(m_data);
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            if (done) begin
                done_at = i;
                break;
            end
        end
        if (done_at < 0) begin
            chk("done_timeout", 0, 1);
        end
        chk("handshake_count", longint'(got.size()), longint'(len));
        chk("read_count", longint'(addrs.size()), longint'(len));
        for (int k = 0; k < got.size() && k < len; k++) begin
            chk("stream_word", longint'(got[k]),
                longint'(spm[(base + k) % DEPTH]));
        end
        for (int k = 0; k < addrs.size() && k < len; k++) begin
            chk("read_addr", longint'(addrs[k]), longint'((base + k) % DEPTH));
        end
        if (exp_done >= 0) begin
            chk("done_latency", longint'(done_at), longint'(exp_done));
        end
        if (len == 0) begin
            chk("len0_no_mem_en", longint'(first_en), -1);
            chk("len0_no_valid", longint'(first_v), -1);
        end else if (mode == 0) begin
            chk("first_mem_en", longint'(first_en), 1);
            chk("first_valid", longint'(first_v), 3);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("busy_low_after_done", longint'(busy), 0);
        chk("done_one_cycle", longint'(done), 0);
    endtask

    initial begin
        int hs;
        int seen_done;
        int seen_act;
        int base;
        int len;
        int mode;
        for (int k = 0; k < DEPTH; k++) begin
            spm[k] = 32'(k) * 32'h0101_0101;
        end
        vecs[0] = '{0, 16, 0, 0, 19};
        vecs[1] = '{14, 4, 0, 0, 7};
        vecs[2] = '{3, 8, 1, 0, -1};
        vecs[3] = '{0, 0, 0, 0, 1};
        vecs[4] = '{0, 16, 0, 1, 19};
        vecs[5] = '{15, 1, 0, 0, 4};

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_mem_en", longint'(mem_en), 0);
        chk("rst_m_valid", longint'(m_valid), 0);
        chk("rst_mem_addr", longint'(mem_addr), 0);
        chk("rst_m_data", longint'(m_data), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode,
                     vecs[v].inject, vecs[v].exp_done);
        end

        // Abort a length-16 transfer with a reset after handshake 6.
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 4'd0;
        length    = 5'd16;
        m_ready   = 1'b1;
        hs = 0;
        for (int i = 0; i < 50 && hs < 6; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            if (m_valid && m_ready) hs++;
        end
        chk("abort_reached_hs6", longint'(hs), 6);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_mem_en", longint'(mem_en), 0);
        chk("abort_m_valid", longint'(m_valid), 0);
        chk("abort_mem_addr", longint'(mem_addr), 0);
        chk("abort_m_data", longint'(m_data), 0);
        seen_done = 0;
        seen_act = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen_done++;
            if (m_valid || mem_en || busy) seen_act++;
        end
        chk("abort_no_done", longint'(seen_done), 0);
        chk("abort_quiet", longint'(seen_act), 0);
        run_xfer(0, 2, 0, 0, 5);

        // Random contents, ranges and backpressure.
        for (int k = 0; k < DEPTH; k++) begin
            spm[k] = $urandom;
        end
        for (int t = 0; t < 24; t++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, DEPTH);
            mode = $urandom_range(0, 1);
            run_xfer(base, len, mode, 0,
                     (mode != 0) ? -1 : ((len == 0) ? 1 : len + 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
